// File: rtl/matrix_mem_responder_if.sv
// Processor and host bus bundle for matrix_mem_responder.
interface matrix_mem_responder_if #(
  parameter int unsigned WIDTH = 32
);
  // Processor port
  logic             procReadEn;
  logic [WIDTH-1:0] procReadAddr;
  logic [WIDTH-1:0] procReadData;
  logic             procWriteEn;
  logic [WIDTH-1:0] procWriteAddr;
  logic [WIDTH-1:0] procWriteData;
  // Host port
  logic             hostValid;
  logic             hostReady;
  logic             hostWrite;
  logic [WIDTH-1:0] hostAddr;
  logic [WIDTH-1:0] hostWdata;
  logic [WIDTH-1:0] hostRdata;
  logic             hostRvalid;
  // Error reporting
  logic             addrError;
  logic             errorClear;

  modport slave (
    input  procReadEn, procReadAddr, procWriteEn, procWriteAddr, procWriteData,
    input  hostValid, hostWrite, hostAddr, hostWdata, errorClear,
    output procReadData, hostReady, hostRdata, hostRvalid, addrError
  );

  modport master (
    output procReadEn, procReadAddr, procWriteEn, procWriteAddr, procWriteData,
    output hostValid, hostWrite, hostAddr, hostWdata, errorClear,
    input  procReadData, hostReady, hostRdata, hostRvalid, addrError
  );
endinterface

// File: rtl/matrix_mem_responder.sv
// Word-array memory responder: processor port with fixed one-cycle read
// latency and absolute priority, host port with valid/ready handshake.
// Optional macro MATRIX_MEM_WRITE_FORWARD_EN bypasses same-cycle write data
// to the read output; undefined means read-first (old data).
module matrix_mem_responder #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 1024,
  parameter logic [WIDTH-1:0] BASE_ADDR = '0
) (
  input logic                   clk,
  input logic                   rst_n,
  matrix_mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [WIDTH-1:0] procReadData_q, procReadData_d;
  logic [WIDTH-1:0] hostRdata_q, hostRdata_d;
  logic             hostRvalid_q, hostRvalid_d;
  logic             addrError_q, addrError_d;

  logic             host_rd_acc_c, host_wr_acc_c;
  logic             wr_req_c, wr_legal_c;
  logic [WIDTH-1:0] wr_addr_c, wr_data_c;
  logic [IDX_W-1:0] wr_idx_c;
  logic             rd_req_c, rd_legal_c;
  logic [WIDTH-1:0] rd_addr_c, rd_word_c;
  logic [IDX_W-1:0] rd_idx_c;
  logic             err_set_c;

  // Byte address is legal when at/above base, word aligned and inside the array
  function automatic logic addr_legal(input logic [WIDTH-1:0] addr);
    logic [WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && (addr[1:0] == 2'b00) &&
           ((off >> 2) < WIDTH'(DEPTH));
  endfunction

  // Word index of a byte address relative to the base
  function automatic logic [IDX_W-1:0] addr_index(input logic [WIDTH-1:0] addr);
    logic [WIDTH-1:0] off;
    off = (addr - BASE_ADDR) >> 2;
    return IDX_W'(off);
  endfunction

  // Host yields whichever array port the processor occupies this cycle
  assign bus.hostReady = !(bus.hostWrite ? bus.procWriteEn : bus.procReadEn);

  // Arbitrate the single write port and the single read port
  always_comb begin
    host_wr_acc_c = 1'b0;
    host_rd_acc_c = 1'b0;
    wr_req_c      = 1'b0;
    wr_addr_c     = '0;
    wr_data_c     = '0;
    rd_req_c      = 1'b0;
    rd_addr_c     = '0;

    host_wr_acc_c = bus.hostValid && bus.hostWrite && !bus.procWriteEn;
    host_rd_acc_c = bus.hostValid && !bus.hostWrite && !bus.procReadEn;

    if (bus.procWriteEn) begin
      wr_req_c  = 1'b1;
      wr_addr_c = bus.procWriteAddr;
      wr_data_c = bus.procWriteData;
    end else if (host_wr_acc_c) begin
      wr_req_c  = 1'b1;
      wr_addr_c = bus.hostAddr;
      wr_data_c = bus.hostWdata;
    end

    if (bus.procReadEn) begin
      rd_req_c  = 1'b1;
      rd_addr_c = bus.procReadAddr;
    end else if (host_rd_acc_c) begin
      rd_req_c  = 1'b1;
      rd_addr_c = bus.hostAddr;
    end
  end

  assign wr_legal_c = wr_req_c && addr_legal(wr_addr_c);
  assign wr_idx_c   = addr_index(wr_addr_c);
  assign rd_legal_c = addr_legal(rd_addr_c);
  assign rd_idx_c   = addr_index(rd_addr_c);
  assign err_set_c  = (wr_req_c && !wr_legal_c) || (rd_req_c && !rd_legal_c);

  // Read word: zero for illegal addresses, optional write bypass
  always_comb begin
    rd_word_c = '0;
    if (rd_legal_c) begin
      rd_word_c = mem_q[rd_idx_c];
`ifdef MATRIX_MEM_WRITE_FORWARD_EN
      if (wr_legal_c && (wr_idx_c == rd_idx_c)) begin
        rd_word_c = wr_data_c;
      end
`endif
    end
  end

  // Next-state for the registered outputs
  always_comb begin
    procReadData_d = procReadData_q;
    hostRdata_d    = hostRdata_q;
    hostRvalid_d   = host_rd_acc_c;
    addrError_d    = addrError_q;
    if (bus.procReadEn) begin
      procReadData_d = rd_word_c;
    end
    if (host_rd_acc_c) begin
      hostRdata_d = rd_word_c;
    end
    if (err_set_c) begin
      addrError_d = 1'b1;
    end else if (bus.errorClear) begin
      addrError_d = 1'b0;
    end
  end

  // Array write; contents survive reset, writes during reset are dropped
  always_ff @(posedge clk) begin
    if (rst_n && wr_legal_c) begin
      mem_q[wr_idx_c] <= wr_data_c;
    end
  end

  // Output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      procReadData_q <= '0;
      hostRdata_q    <= '0;
      hostRvalid_q   <= 1'b0;
      addrError_q    <= 1'b0;
    end else begin
      procReadData_q <= procReadData_d;
      hostRdata_q    <= hostRdata_d;
      hostRvalid_q   <= hostRvalid_d;
      addrError_q    <= addrError_d;
    end
  end

  assign bus.procReadData = procReadData_q;
  assign bus.hostRdata    = hostRdata_q;
  assign bus.hostRvalid   = hostRvalid_q;
  assign bus.addrError    = addrError_q;

endmodule

// File: tb/tb_matrix_mem_responder.sv
// Directed bench for matrix_mem_responder (WIDTH=32, DEPTH=1024, BASE_ADDR=0).
module tb_matrix_mem_responder;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  matrix_mem_responder_if #(.WIDTH(32)) bus ();

  matrix_mem_responder #(
    .WIDTH    (32),
    .DEPTH    (1024),
    .BASE_ADDR(32'h0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge; returns 1ns after it so registered outputs are stable
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] preload(input int i);
    return (i == 4) ? 32'h1111_1111 : (32'hA000_0000 + 32'(i));
  endfunction

  logic [31:0] exp_fwd;

  initial begin
    total = 0;
    bad   = 0;
`ifdef MATRIX_MEM_WRITE_FORWARD_EN
    exp_fwd = 32'hDEAD_BEEF;
`else
    exp_fwd = 32'hA000_0008;
`endif
    rst_n             = 1'b0;
    bus.procReadEn    = 1'b0;
    bus.procReadAddr  = '0;
    bus.procWriteEn   = 1'b0;
    bus.procWriteAddr = '0;
    bus.procWriteData = '0;
    bus.hostValid     = 1'b0;
    bus.hostWrite     = 1'b0;
    bus.hostAddr      = '0;
    bus.hostWdata     = '0;
    bus.errorClear    = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    check("rst_procReadData", bus.procReadData, 32'h0);
    check("rst_hostRdata", bus.hostRdata, 32'h0);
    check("rst_hostRvalid", 32'(bus.hostRvalid), 32'h0);
    check("rst_addrError", 32'(bus.addrError), 32'h0);

    // Host write then host read of 0x10
    bus.hostValid = 1'b1; bus.hostWrite = 1'b1;
    bus.hostAddr = 32'h10; bus.hostWdata = 32'h1111_1111;
    #1;
    check("host_wr_ready", 32'(bus.hostReady), 32'h1);
    step();
    bus.hostWrite = 1'b0;
    #1;
    check("host_rd_ready", 32'(bus.hostReady), 32'h1);
    step();
    bus.hostValid = 1'b0;
    check("host_rd_rvalid", 32'(bus.hostRvalid), 32'h1);
    check("host_rd_data", bus.hostRdata, 32'h1111_1111);
    step();
    check("host_rd_rvalid_drop", 32'(bus.hostRvalid), 32'h0);

    // Preload words 0..15 through the host port
    for (int i = 0; i < 16; i++) begin
      bus.hostValid = 1'b1; bus.hostWrite = 1'b1;
      bus.hostAddr = 32'(4 * i); bus.hostWdata = preload(i);
      step();
    end
    bus.hostValid = 1'b0; bus.hostWrite = 1'b0;

    // Processor single read with one-cycle latency, then hold
    bus.procReadEn = 1'b1; bus.procReadAddr = 32'h10;
    step();
    bus.procReadEn = 1'b0;
    check("proc_rd_0x10", bus.procReadData, 32'h1111_1111);
    bus.procReadAddr = 32'h0;
    step();
    check("proc_rd_hold", bus.procReadData, 32'h1111_1111);

    // Sixteen back-to-back processor reads
    for (int i = 0; i < 16; i++) begin
      bus.procReadEn = 1'b1; bus.procReadAddr = 32'(4 * i);
      step();
      check($sformatf("proc_burst_%0d", i), bus.procReadData, preload(i));
    end
    bus.procReadEn = 1'b0;

    // Host read stalls for three processor-read cycles
    bus.procReadEn = 1'b1; bus.procReadAddr = 32'h0;
    bus.hostValid = 1'b1; bus.hostWrite = 1'b0; bus.hostAddr = 32'h10;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall_ready_%0d", k), 32'(bus.hostReady), 32'h0);
      step();
      check($sformatf("stall_rvalid_%0d", k), 32'(bus.hostRvalid), 32'h0);
    end
    bus.procReadEn = 1'b0;
    #1;
    check("stall_release_ready", 32'(bus.hostReady), 32'h1);
    step();
    bus.hostValid = 1'b0;
    check("stall_rvalid", 32'(bus.hostRvalid), 32'h1);
    check("stall_rdata", bus.hostRdata, 32'h1111_1111);

    // Host write alongside a processor read is accepted at once
    bus.procReadEn = 1'b1; bus.procReadAddr = 32'h0;
    bus.hostValid = 1'b1; bus.hostWrite = 1'b1;
    bus.hostAddr = 32'h40; bus.hostWdata = 32'h55AA_55AA;
    #1;
    check("hwr_during_prd_ready", 32'(bus.hostReady), 32'h1);
    step();
    bus.procReadEn = 1'b0;
    bus.hostWrite = 1'b0;
    check("hwr_during_prd_pdata", bus.procReadData, 32'hA000_0000);
    step();
    bus.hostValid = 1'b0;
    check("hwr_readback", bus.hostRdata, 32'h55AA_55AA);

    // Processor write and host read of the same word in one cycle
    bus.procWriteEn = 1'b1; bus.procWriteAddr = 32'h20; bus.procWriteData = 32'hDEAD_BEEF;
    bus.hostValid = 1'b1; bus.hostWrite = 1'b0; bus.hostAddr = 32'h20;
    #1;
    check("collide_ready", 32'(bus.hostReady), 32'h1);
    step();
    bus.procWriteEn = 1'b0; bus.hostValid = 1'b0;
    check("collide_hrdata", bus.hostRdata, exp_fwd);
    bus.procReadEn = 1'b1; bus.procReadAddr = 32'h20;
    step();
    bus.procReadEn = 1'b0;
    check("collide_new_word", bus.procReadData, 32'hDEAD_BEEF);

    // Misaligned processor write and out-of-range host read
    check("err_pre", 32'(bus.addrError), 32'h0);
    bus.procWriteEn = 1'b1; bus.procWriteAddr = 32'h22; bus.procWriteData = 32'h1234_5678;
    bus.hostValid = 1'b1; bus.hostWrite = 1'b0; bus.hostAddr = 32'h1000;
    step();
    bus.procWriteEn = 1'b0; bus.hostValid = 1'b0;
    check("err_set", 32'(bus.addrError), 32'h1);
    check("err_rd_rvalid", 32'(bus.hostRvalid), 32'h1);
    check("err_rd_zero", bus.hostRdata, 32'h0);
    bus.procReadEn = 1'b1; bus.procReadAddr = 32'h20;
    step();
    check("err_wr_dropped", bus.procReadData, 32'hDEAD_BEEF);
    bus.procReadAddr = 32'h1000; bus.errorClear = 1'b1;
    step();
    bus.procReadEn = 1'b0;
    check("err_set_wins", 32'(bus.addrError), 32'h1);
    check("err_prd_zero", bus.procReadData, 32'h0);
    step();
    bus.errorClear = 1'b0;
    check("err_cleared", 32'(bus.addrError), 32'h0);

    // Reset while a host read response is pending
    bus.procReadEn = 1'b1; bus.procReadAddr = 32'h20;
    step();
    bus.procReadEn = 1'b0;
    bus.hostValid = 1'b1; bus.hostWrite = 1'b0; bus.hostAddr = 32'h10;
    step();
    bus.hostValid = 1'b0;
    check("pre_rst_rvalid", 32'(bus.hostRvalid), 32'h1);
    check("pre_rst_pdata", bus.procReadData, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    bus.procWriteEn = 1'b1; bus.procWriteAddr = 32'h10; bus.procWriteData = 32'hBAD0_BAD0;
    step();
    rst_n = 1'b1;
    bus.procWriteEn = 1'b0;
    check("mid_rst_rvalid", 32'(bus.hostRvalid), 32'h0);
    check("mid_rst_pdata", bus.procReadData, 32'h0);
    check("mid_rst_hdata", bus.hostRdata, 32'h0);
    bus.procReadEn = 1'b1; bus.procReadAddr = 32'h10;
    step();
    bus.procReadEn = 1'b0;
    check("post_rst_mem", bus.procReadData, 32'h1111_1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
